// File: rtl/mpu_load_unit_if.sv
// Load unit bus: command, memory stream and register file write port.
// master = load unit side, slave = command/memory/register file side.
interface mpu_load_unit_if #(
  parameter int M                = 4,
  parameter int N                = 4,
  parameter int MATRIX_REGISTERS = 8
);
  localparam int MBITS = $clog2(M);
  localparam int NBITS = $clog2(N);
  localparam int RBITS = $clog2(MATRIX_REGISTERS);

  logic             cmd_req_in;
  logic             cmd_ready_out;
  logic [RBITS:0]   cmd_addr_in;
  logic [MBITS:0]   cmd_m_in;
  logic [NBITS:0]   cmd_n_in;
`ifdef MPU_LOAD_TRANSPOSE_EN
  logic             cmd_transpose_in;
`endif
  logic             mem_valid_in;
  logic             mem_ready_out;
  logic [31:0]      mem_element_in;
  logic             reg_load_req_out;
  logic             reg_load_ready_in;
  logic [RBITS:0]   reg_load_addr_out;
  logic [MBITS:0]   reg_i_load_loc_out;
  logic [NBITS:0]   reg_j_load_loc_out;
  logic [MBITS:0]   reg_m_load_size_out;
  logic [NBITS:0]   reg_n_load_size_out;
  logic [31:0]      reg_load_element_out;
  logic             load_done_out;
  logic             load_error_out;

  modport master (
`ifdef MPU_LOAD_TRANSPOSE_EN
    input  cmd_transpose_in,
`endif
    input  cmd_req_in,
    output cmd_ready_out,
    input  cmd_addr_in,
    input  cmd_m_in,
    input  cmd_n_in,
    input  mem_valid_in,
    output mem_ready_out,
    input  mem_element_in,
    output reg_load_req_out,
    input  reg_load_ready_in,
    output reg_load_addr_out,
    output reg_i_load_loc_out,
    output reg_j_load_loc_out,
    output reg_m_load_size_out,
    output reg_n_load_size_out,
    output reg_load_element_out,
    output load_done_out,
    output load_error_out
  );

  modport slave (
`ifdef MPU_LOAD_TRANSPOSE_EN
    output cmd_transpose_in,
`endif
    output cmd_req_in,
    input  cmd_ready_out,
    output cmd_addr_in,
    output cmd_m_in,
    output cmd_n_in,
    output mem_valid_in,
    input  mem_ready_out,
    output mem_element_in,
    input  reg_load_req_out,
    output reg_load_ready_in,
    input  reg_load_addr_out,
    input  reg_i_load_loc_out,
    input  reg_j_load_loc_out,
    input  reg_m_load_size_out,
    input  reg_n_load_size_out,
    input  reg_load_element_out,
    input  load_done_out,
    input  load_error_out
  );
endinterface

// File: rtl/mpu_load_unit.sv
// MPU matrix loader: streams elements into the register file load port.
// Optional MPU_LOAD_TRANSPOSE_EN adds column-major (transposed) ordering.
module mpu_load_unit #(
  parameter int M                = 4,
  parameter int N                = 4,
  parameter int MATRIX_REGISTERS = 8
) (
  input logic           clk,
  input logic           rst,
  mpu_load_unit_if.master bus
);
  localparam int MBITS = $clog2(M);
  localparam int NBITS = $clog2(N);
  localparam int RBITS = $clog2(MATRIX_REGISTERS);
  localparam int CW    = MBITS + NBITS + 2;

  localparam logic [MBITS:0] M_MAX = (MBITS+1)'(M);
  localparam logic [NBITS:0] N_MAX = (NBITS+1)'(N);
  localparam logic [RBITS:0] R_MAX = (RBITS+1)'(MATRIX_REGISTERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [RBITS:0] addr_q;
  logic [MBITS:0] m_q, i_q, i_nx;
  logic [NBITS:0] n_q, j_q, j_nx;
  logic [31:0]    elem_q;
  logic [CW-1:0]  acc_cnt, wr_cnt, total;
  logic           req_q, done_q, err_q, rdy_q;
  logic           tr_q;
  logic           mem_rdy;
  logic           cmd_fire, cmd_bad, cmd_ok;
  logic           acc, ret, last_ret;

  assign cmd_fire = bus.cmd_req_in & rdy_q;
  assign cmd_bad  = (bus.cmd_m_in == '0) |
                    (bus.cmd_n_in == '0) |
                    (bus.cmd_m_in > M_MAX) |
                    (bus.cmd_n_in > N_MAX) |
                    (bus.cmd_addr_in >= R_MAX);
  assign cmd_ok   = cmd_fire & ~cmd_bad;

  assign total    = CW'(m_q) * CW'(n_q);
  assign acc      = bus.mem_valid_in & mem_rdy;
  assign ret      = req_q & bus.reg_load_ready_in;
  assign last_ret = ret & (wr_cnt == total - CW'(1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and memory-side ready
  always_comb begin
    state_d = state_q;
    mem_rdy = 1'b0;
    unique case (state_q)
      IDLE: if (cmd_ok) state_d = LOAD;
      LOAD: begin
        mem_rdy = (acc_cnt != total) &
                  (~req_q | bus.reg_load_ready_in);
        if (last_ret) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef MPU_LOAD_TRANSPOSE_EN
  // Ordering mode captured with the command
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        tr_q <= 1'b0;
    else if (cmd_ok) tr_q <= bus.cmd_transpose_in;
  end
`else
  assign tr_q = 1'b0;
`endif

  // Command latch, slot, location walk and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      m_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      i_nx    <= '0;
      j_nx    <= '0;
      elem_q  <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      err_q  <= cmd_fire & cmd_bad;
      done_q <= last_ret;
      rdy_q  <= (state_d == IDLE);
      if (cmd_ok) begin
        addr_q  <= bus.cmd_addr_in;
        m_q     <= bus.cmd_m_in;
        n_q     <= bus.cmd_n_in;
        i_nx    <= '0;
        j_nx    <= '0;
        acc_cnt <= '0;
        wr_cnt  <= '0;
      end
      if (ret) wr_cnt <= wr_cnt + CW'(1);
      if (acc) begin
        elem_q  <= bus.mem_element_in;
        i_q     <= i_nx;
        j_q     <= j_nx;
        acc_cnt <= acc_cnt + CW'(1);
        if (tr_q) begin
          if (i_nx == m_q - (MBITS+1)'(1)) begin
            i_nx <= '0;
            j_nx <= j_nx + (NBITS+1)'(1);
          end else begin
            i_nx <= i_nx + (MBITS+1)'(1);
          end
        end else begin
          if (j_nx == n_q - (NBITS+1)'(1)) begin
            j_nx <= '0;
            i_nx <= i_nx + (MBITS+1)'(1);
          end else begin
            j_nx <= j_nx + (NBITS+1)'(1);
          end
        end
      end
      if (acc)      req_q <= 1'b1;
      else if (ret) req_q <= 1'b0;
    end
  end

  assign bus.cmd_ready_out        = rdy_q;
  assign bus.mem_ready_out        = mem_rdy;
  assign bus.reg_load_req_out     = req_q;
  assign bus.reg_load_addr_out    = addr_q;
  assign bus.reg_i_load_loc_out   = i_q;
  assign bus.reg_j_load_loc_out   = j_q;
  assign bus.reg_m_load_size_out  = m_q;
  assign bus.reg_n_load_size_out  = n_q;
  assign bus.reg_load_element_out = elem_q;
  assign bus.load_done_out        = done_q;
  assign bus.load_error_out       = err_q;
endmodule

// File: doc/mpu_load_unit.md
Name: mpu_load_unit

Overview:
Memory-side loader that sits directly upstream of the MPU matrix register file's load port. It accepts a load command: destination register, row count and column count. It then consumes a stream of single-precision elements from memory over a valid/ready handshake. Each element is presented to the register file together with its (i,j) location, and the unit respects the register file's load-ready backpressure. When the whole matrix has been written, it pulses done.

Parameters:
M, 4, maximum matrix rows; MBITS = $clog2(M), row ports are [MBITS:0]
N, 4, maximum matrix columns; NBITS = $clog2(N), column ports are [NBITS:0]
MATRIX_REGISTERS, 8, number of matrix registers; MATRIX_REG_BITS = $clog2(MATRIX_REGISTERS), address ports are [MATRIX_REG_BITS:0]

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cmd_req_in  in  1  load command strobe
cmd_ready_out  out  1  high in IDLE; a command is accepted on cmd_req_in & cmd_ready_out
cmd_addr_in  in  MATRIX_REG_BITS+1  destination matrix register
cmd_m_in  in  MBITS+1  matrix rows
cmd_n_in  in  NBITS+1  matrix columns
mem_valid_in  in  1  memory element valid
mem_ready_out  out  1  unit can take an element this cycle
mem_element_in  in  32  float_sp element
reg_load_req_out  out  1  write request to the register file
reg_load_ready_in  in  1  register file load ready
reg_load_addr_out  out  MATRIX_REG_BITS+1  destination register
reg_i_load_loc_out  out  MBITS+1  element row
reg_j_load_loc_out  out  NBITS+1  element column
reg_m_load_size_out  out  MBITS+1  latched row count
reg_n_load_size_out  out  NBITS+1  latched column count
reg_load_element_out  out  32  element data
load_done_out  out  1  one-cycle pulse when the last element is written
load_error_out  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs and internal counters go to 0; any in-flight element is discarded. After reset, cmd_ready_out=1 from the first clock edge.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - cmd_ready_out=1, mem_ready_out=0, reg_load_req_out=0.
  - On command accept, the command is illegal if: m==0, n==0, m>M, n>N, or addr>=MATRIX_REGISTERS.
  - Illegal command: load_error_out=1 for the next cycle; state stays IDLE.
  - Legal command: latch addr, m and n onto the reg_* outputs; clear i_next/j_next to 0; go to LOAD.
- LOAD, handshakes:
  - The output stage is a single-entry holding register ("slot").
  - mem_ready_out = (not all m*n elements yet accepted) & (slot empty | (reg_load_req_out & reg_load_ready_in)).
  - Element accept: on mem_valid_in & mem_ready_out, the element is written into the slot at (i_next,j_next). reg_load_req_out=1 from the next cycle.
- LOAD, write retire:
  - A write retires on the edge where reg_load_req_out & reg_load_ready_in.
  - reg_load_req_out drops after retire unless a new element is captured on the same edge, so back-to-back writes sustain one element per cycle.
  - Slot contents (element, i, j) stay stable while reg_load_req_out=1 and reg_load_ready_in=0.
- Ordering: row-major. j increments; at j==n-1, j wraps to 0 and i increments.
  - After element (m-1,n-1) is accepted, mem_ready_out stays 0 for the rest of the command.
  - Latency: accept at edge k, request visible after edge k, earliest write at edge k+1.
- Transition to DONE: on retire of the last element (write count == m*n).
- DONE: load_done_out=1 for exactly one cycle, then IDLE. A command cannot be accepted in DONE.
- Multiplies use MBITS+NBITS+2-bit width; there is no overflow given the legality checks.
- Mid-load: cmd_req_in is ignored outside IDLE, and load_error_out is not asserted for it.
- Reset mid-load: the partial matrix stays in the register file; the unit returns to IDLE with no done pulse.

Optional Feature:
MPU_LOAD_TRANSPOSE_EN
- Defined: adds input cmd_transpose_in (1 bit), latched at command accept. When it is set, the order becomes column-major: i increments, and at i==m-1 it wraps to 0 while j increments. The stream is therefore stored transposed relative to a row-major memory layout. The m and n outputs are unchanged.
- Undefined: the port does not exist and the order is always row-major.

Test Plan:
- Basic load: cmd addr=2, m=2, n=3; mem_valid held high with elements 1.0..6.0; reg_load_ready_in=1 → six consecutive requests at (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) with matching data; load_done_out pulses one cycle after the 6th write; then cmd_ready_out=1.
- Backpressure: 2x2 load with reg_load_ready_in low for 3 cycles after the first request → slot holds (0,0) and its data stable, mem_ready_out=0 throughout, no element lost or duplicated; done after 4 writes.
- Memory gaps: 3x3 load with mem_valid_in alternating 1/0 → 9 writes in order; reg_load_req_out deasserts during gaps; single done pulse.
- Illegal commands: m=0; n=N+1; addr=MATRIX_REGISTERS → each gives load_error_out pulse, state stays IDLE, mem_ready_out stays 0, no writes.
- Reset mid-load: rst low after 2 of 4 elements → all outputs 0 immediately; no done pulse; a new 1x1 command afterwards completes normally.
- With MPU_LOAD_TRANSPOSE_EN: 2x3 load, cmd_transpose_in=1, elements 1..6 → locations (0,0),(1,0),(0,1),(1,1),(0,2),(1,2).
